// File: rtl/alu_vector_gen.sv
// alu_vector_gen: pseudo-random stimulus source for a 32-bit MIPS-style ALU.
// Emits {ctrl, op1, op2} vectors with golden {exp_result, exp_zero} over valid/ready,
// counts completed handshakes and raises done after NUM_VECTORS of them.
//
// Ports:
//   clock        single clock, all state on posedge
//   reset        synchronous, active-high
//   start        level; begins a run when sampled in IDLE or DONE
//   out_valid    payload valid
//   out_ready    consumer accepts payload when out_valid && out_ready
//   ctrl         ALU opcode
//   op1, op2     operands
//   exp_result   golden ALU result
//   exp_zero     golden zero flag
//   sent         handshakes completed this run
//   done         run complete
//
// Optional feature: define ALU_VECGEN_CORNER_EN to emit a fixed table of eight corner-case
// vectors at the start of every run (LFSRs hold while the table is being emitted).
module alu_vector_gen #(
  parameter int unsigned NUM_VECTORS = 100,
  parameter logic [31:0] SEED        = 32'h0000_0001
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  ctrl,
  output logic [31:0] op1,
  output logic [31:0] op2,
  output logic [31:0] exp_result,
  output logic        exp_zero,
  output logic [15:0] sent,
  output logic        done
);

  localparam logic [31:0] Taps     = 32'h8020_0003;
  localparam logic [31:0] SeedBRaw = SEED ^ 32'hA5A5_A5A5;
  // An all-zero Galois LFSR never leaves zero.
  localparam logic [31:0] SeedB    = (SeedBRaw == 32'h0) ? 32'h1 : SeedBRaw;
  localparam logic [15:0] NumVec   = 16'(NUM_VECTORS);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic logic [31:0] lfsr_step(logic [31:0] s);
    return (s >> 1) ^ (s[0] ? Taps : 32'h0);
  endfunction

  function automatic logic [31:0] alu_model(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    logic [4:0]  sa;
    logic [31:0] r;
    sa = b[4:0];
    case (c)
      4'd0:    r = a << sa;
      4'd1:    r = a >> sa;
      4'd2:    r = $unsigned($signed(a) >>> sa);
      4'd3:    r = a + b;
      4'd4:    r = a - b;
      4'd5:    r = a & b;
      4'd6:    r = a | b;
      4'd7:    r = a ^ b;
      4'd8:    r = ~(a | b);
      4'd9:    r = (a < b) ? 32'd1 : 32'd0;
      4'd10:   r = {a[15:0], 16'h0};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

`ifdef ALU_VECGEN_CORNER_EN
  localparam logic [15:0] NumCorner = (NUM_VECTORS < 8) ? 16'(NUM_VECTORS) : 16'd8;

  // {ctrl, op1, op2}
  function automatic logic [67:0] corner_vec(logic [2:0] i);
    logic [67:0] v;
    case (i)
      3'd0:    v = {4'd0,  32'h0000_0001, 32'd31};
      3'd1:    v = {4'd2,  32'h8000_0000, 32'd31};
      3'd2:    v = {4'd1,  32'h8000_0000, 32'd31};
      3'd3:    v = {4'd3,  32'hFFFF_FFFF, 32'h0000_0001};
      3'd4:    v = {4'd4,  32'h0000_0000, 32'h0000_0001};
      3'd5:    v = {4'd9,  32'h7FFF_FFFF, 32'h8000_0000};
      3'd6:    v = {4'd8,  32'h0000_0000, 32'h0000_0000};
      default: v = {4'd10, 32'h0000_ABCD, 32'h0000_0000};
    endcase
    return v;
  endfunction
`endif

  state_e      state_q, state_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;
  logic [15:0] sent_q, sent_d;
  logic [15:0] loaded_q, loaded_d;
  logic [31:0] lfsr_a_q, lfsr_a_d;
  logic [31:0] lfsr_b_q, lfsr_b_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d;

  logic [3:0]  vec_ctrl;
  logic [31:0] vec_op1, vec_op2, vec_res;
  logic        vec_step;
  logic        hs, load;

  // Candidate next vector and its golden result.
  always_comb begin
    vec_ctrl = lfsr_a_q[3:0] ^ lfsr_b_q[7:4];
    vec_op1  = lfsr_a_q;
    vec_op2  = lfsr_b_q;
    vec_step = 1'b1;
`ifdef ALU_VECGEN_CORNER_EN
    if (loaded_q < NumCorner) begin
      {vec_ctrl, vec_op1, vec_op2} = corner_vec(loaded_q[2:0]);
      vec_step = 1'b0;
    end
`endif
    vec_res = alu_model(vec_ctrl, vec_op1, vec_op2);
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    done_d   = done_q;
    sent_d   = sent_q;
    loaded_d = loaded_q;
    lfsr_a_d = lfsr_a_q;
    lfsr_b_d = lfsr_b_q;
    ctrl_d   = ctrl_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    res_d    = res_q;
    zero_d   = zero_q;
    hs       = valid_q && out_ready;
    load     = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StRun;
          done_d   = 1'b0;
          valid_d  = 1'b0;
          sent_d   = 16'd0;
          loaded_d = 16'd0;
          lfsr_a_d = SEED;
          lfsr_b_d = SeedB;
        end
      end
      StRun: begin
        if (hs) sent_d = sent_q + 16'd1;
        if (hs && (sent_q + 16'd1 == NumVec)) begin
          state_d = StDone;
          valid_d = 1'b0;
          done_d  = 1'b1;
        end else if (!valid_q || out_ready) begin
          if (loaded_q < NumVec) load = 1'b1;
          else                   valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      valid_d  = 1'b1;
      loaded_d = loaded_q + 16'd1;
      ctrl_d   = vec_ctrl;
      op1_d    = vec_op1;
      op2_d    = vec_op2;
      res_d    = vec_res;
      zero_d   = (vec_res == 32'h0);
      if (vec_step) begin
        lfsr_a_d = lfsr_step(lfsr_a_q);
        lfsr_b_d = lfsr_step(lfsr_b_q);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      sent_q   <= 16'd0;
      loaded_q <= 16'd0;
      lfsr_a_q <= SEED;
      lfsr_b_q <= SeedB;
      ctrl_q   <= 4'd0;
      op1_q    <= 32'h0;
      op2_q    <= 32'h0;
      res_q    <= 32'h0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      sent_q   <= sent_d;
      loaded_q <= loaded_d;
      lfsr_a_q <= lfsr_a_d;
      lfsr_b_q <= lfsr_b_d;
      ctrl_q   <= ctrl_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
    end
  end

  assign out_valid  = valid_q;
  assign done       = done_q;
  assign sent       = sent_q;
  assign ctrl       = ctrl_q;
  assign op1        = op1_q;
  assign op2        = op2_q;
  assign exp_result = res_q;
  assign exp_zero   = zero_q;

endmodule
